// File: rtl/wait_time_calc_pkg.sv
// Shared FSM encoding and width-derivation helpers for the wait-time calculator.
// Constant functions only; no logic, no latency, no backpressure.
package wait_calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int st_w(input int service_time);
    return clog2(service_time + 1);
  endfunction

  function automatic int divd_w(input int count_w, input int teller_w, input int service_time);
    return count_w + teller_w + st_w(service_time);
  endfunction

endpackage

// File: rtl/wait_time_calc_if.sv
// Request/result bundle between the queue counter and the wait-time calculator.
// start/done handshake; requests during a busy computation are dropped.
interface wait_time_calc_if #(
  parameter int COUNT_W  = 3,
  parameter int TELLER_W = 2,
  parameter int OUT_W    = 8
);
  logic                start;
  logic [COUNT_W-1:0]  count;
  logic [TELLER_W-1:0] tellers;
  logic                busy;
  logic                done;
  logic                err;
  logic [OUT_W-1:0]    wait_time;

  modport master (
    output start, count, tellers,
    input  busy, done, err, wait_time
  );

  modport slave (
    input  start, count, tellers,
    output busy, done, err, wait_time
  );
endinterface

// File: rtl/wait_time_calc_divider.sv
// Unsigned restoring divider, one quotient bit per cycle MSB first; done pulses on the W-th step.
// Latency W cycles after load; a load while running restarts it, no other backpressure.
module seq_divider #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);
  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     rem_q;
  logic [W-1:0]     quot_q;
  logic [W-1:0]     dvs_q;
  logic [CNT_W-1:0] cnt_q;

  logic [W:0]   partial;
  logic [W:0]   diff;
  logic         qbit;
  logic [W-1:0] rem_nxt;

  always_comb begin
    partial = {rem_q, quot_q[W-1]};
    diff    = partial - {1'b0, dvs_q};
    qbit    = ~diff[W];
    rem_nxt = qbit ? diff[W-1:0] : partial[W-1:0];
  end

  assign busy     = (cnt_q != '0);
  assign done     = (cnt_q == CNT_W'(1));
  // Valid only while done is high: the final bit is folded in combinationally.
  assign quotient = {quot_q[W-2:0], qbit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      rem_q  <= '0;
      quot_q <= dividend;
      dvs_q  <= divisor;
      cnt_q  <= CNT_W'(W);
    end else if (busy) begin
      rem_q  <= rem_nxt;
      quot_q <= {quot_q[W-2:0], qbit};
      cnt_q  <= cnt_q - CNT_W'(1);
    end
  end
endmodule

// File: rtl/wait_time_calc.sv
// Wait = floor(SERVICE_TIME*(count+tellers-1)/tellers); DIVD_W+2 cycles, 1 for zero/illegal; start ignored unless IDLE.
// Optional macro WAIT_SAT_EN clamps an oversized quotient to all-ones instead of truncating it.
module wait_time_calc
  import wait_calc_pkg::*;
#(
  parameter int COUNT_W      = 3,
  parameter int TELLER_W     = 2,
  parameter int MAX_TELLERS  = 3,
  parameter int SERVICE_TIME = 3,
  parameter int OUT_W        = 8
) (
  input logic             clk,
  input logic             rst_n,
  wait_time_calc_if.slave bus
);
  localparam int DIVD_W = divd_w(COUNT_W, TELLER_W, SERVICE_TIME);
  localparam logic [DIVD_W-1:0] ST_V = DIVD_W'(SERVICE_TIME);

  state_t              state, state_nxt;
  logic [COUNT_W-1:0]  cnt_q;
  logic [TELLER_W-1:0] tel_q;
  logic                err_q;
  logic [OUT_W-1:0]    wt_q;

  logic              accept;
  logic              illegal;
  logic [DIVD_W-1:0] dividend;
  logic              div_busy;
  logic              div_done;
  logic [DIVD_W-1:0] div_quot;
  logic [OUT_W-1:0]  res;

  assign accept   = (state == IDLE) && bus.start;
  assign illegal  = (bus.tellers == '0) || (32'(bus.tellers) > MAX_TELLERS);
  assign dividend = ST_V * (DIVD_W'(cnt_q) + DIVD_W'(tel_q) - DIVD_W'(1));

  seq_divider #(.W(DIVD_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == MUL),
    .dividend (dividend),
    .divisor  (DIVD_W'(tel_q)),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  always_comb begin
    res = OUT_W'(div_quot);
`ifdef WAIT_SAT_EN
    if ((div_quot >> OUT_W) != '0) res = '1;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (illegal || bus.count == '0) ? DONE : MUL;
      MUL:  state_nxt = DIV;
      DIV:  if (div_done) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt_q <= '0;
      tel_q <= '0;
      err_q <= 1'b0;
      wt_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt_q <= bus.count;
        tel_q <= bus.tellers;
        err_q <= illegal;
        wt_q  <= '0;
      end else if (state == DIV && div_done) begin
        wt_q <= res;
      end
    end
  end

  assign bus.busy      = (state != IDLE) || div_busy;
  assign bus.done      = (state == DONE);
  assign bus.err       = err_q;
  assign bus.wait_time = wt_q;
endmodule

// File: tb/tb_wait_time_calc.sv
// Randomized self-checking bench for wait_time_calc against an arithmetic reference model.
module tb_wait_time_calc;
  localparam int COUNT_W = 3;
  localparam int TELLER_W = 2;
  localparam int MAXT = 3;
  localparam int ST = 3;
`ifdef WAIT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int total;
  int bad;

  wait_time_calc_if #(.COUNT_W(COUNT_W), .TELLER_W(TELLER_W), .OUT_W(8)) bus ();
  wait_time_calc_if #(.COUNT_W(COUNT_W), .TELLER_W(TELLER_W), .OUT_W(4)) bus4 ();

  wait_time_calc #(.COUNT_W(COUNT_W), .TELLER_W(TELLER_W), .MAX_TELLERS(MAXT),
                   .SERVICE_TIME(ST), .OUT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  wait_time_calc #(.COUNT_W(COUNT_W), .TELLER_W(TELLER_W), .MAX_TELLERS(MAXT),
                   .SERVICE_TIME(ST), .OUT_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model(input int c, input int t, input int ow, input bit sat);
    int q;
    int lim;
    if (t == 0 || t > MAXT || c == 0) return 0;
    q = (ST * (c + t - 1)) / t;
    lim = (1 << ow) - 1;
    if (q > lim) q = sat ? lim : (q % (1 << ow));
    return q;
  endfunction

  function automatic int model_lat(input int c, input int t);
    return (t == 0 || t > MAXT || c == 0) ? 1 : COUNT_W + TELLER_W + 2 + 2;
  endfunction

  task automatic do_req(input int c, input int t, output int lat, output int wt, output logic e);
    bus.count = COUNT_W'(c);
    bus.tellers = TELLER_W'(t);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (bus.done) begin
        lat = i;
        break;
      end
      bus.count = COUNT_W'($urandom);
      bus.tellers = TELLER_W'($urandom);
      @(posedge clk); #1;
    end
    wt = int'(bus.wait_time);
    e = bus.err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.count = '0; bus.tellers = '0;
    bus4.start = 1'b0; bus4.count = '0; bus4.tellers = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.err); end
    total++; if (bus.wait_time !== 8'd0) begin bad++; $display("FAIL reset_wt got=%0d want=0", bus.wait_time); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    int lat, wt;
    logic e;
    for (int t = 1; t <= 3; t++) begin
      for (int c = 0; c <= 7; c++) begin
        do_req(c, t, lat, wt, e);
        total++; if (wt != model(c, t, 8, SAT)) begin bad++; $display("FAIL sweep_wt t=%0d c=%0d got=%0d want=%0d", t, c, wt, model(c, t, 8, SAT)); end
        total++; if (lat != model_lat(c, t)) begin bad++; $display("FAIL sweep_lat t=%0d c=%0d got=%0d want=%0d", t, c, lat, model_lat(c, t)); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL sweep_err t=%0d c=%0d got=%b want=0", t, c, e); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid_div();
    int lat, wt;
    logic e;
    bus.count = 3'd7; bus.tellers = 2'd1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL middiv_busy_before got=%b want=1", bus.busy); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL middiv_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL middiv_done got=%b want=0", bus.done); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL middiv_err got=%b want=0", bus.err); end
    total++; if (bus.wait_time !== 8'd0) begin bad++; $display("FAIL middiv_wt got=%0d want=0", bus.wait_time); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(4, 3, lat, wt, e);
    total++; if (wt != model(4, 3, 8, SAT)) begin bad++; $display("FAIL middiv_after_wt got=%0d want=%0d", wt, model(4, 3, 8, SAT)); end
    total++; if (lat != 9) begin bad++; $display("FAIL middiv_after_lat got=%0d want=9", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    int lat, wt;
    logic e;
    do_req(5, 0, lat, wt, e);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL illegal_err got=%b want=1", e); end
    total++; if (wt != 0) begin bad++; $display("FAIL illegal_wt got=%0d want=0", wt); end
    total++; if (lat != 1) begin bad++; $display("FAIL illegal_lat got=%0d want=1", lat); end
    @(posedge clk); #1;
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL illegal_err_hold got=%b want=1", bus.err); end
    do_req(5, 2, lat, wt, e);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL legal_err got=%b want=0", e); end
    total++; if (wt != 9) begin bad++; $display("FAIL legal_wt got=%0d want=9", wt); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_while_busy();
    int ndone, lat, wt;
    ndone = 0; lat = -1; wt = -1;
    bus.count = 3'd7; bus.tellers = 2'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      if (bus.done) begin
        ndone++;
        if (lat < 0) begin lat = cyc; wt = int'(bus.wait_time); end
      end
      bus.start = (cyc == 4);
      if (cyc == 4) begin bus.count = 3'd7; bus.tellers = 2'd1; end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    total++; if (ndone != 1) begin bad++; $display("FAIL busy_ndone got=%0d want=1", ndone); end
    total++; if (wt != 9) begin bad++; $display("FAIL busy_wt got=%0d want=9", wt); end
    total++; if (lat != 9) begin bad++; $display("FAIL busy_lat got=%0d want=9", lat); end
  endtask

  task automatic test_hold_back_to_back();
    int lat, wt, exp;
    logic e;
    do_req(6, 2, lat, wt, e);
    exp = model(6, 2, 8, SAT);
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      bus.count = COUNT_W'($urandom);
      bus.tellers = TELLER_W'($urandom);
      total++; if (int'(bus.wait_time) != exp) begin bad++; $display("FAIL hold_wt cyc=%0d got=%0d want=%0d", i, bus.wait_time, exp); end
      @(posedge clk); #1;
    end
    do_req(4, 1, lat, wt, e);
    @(posedge clk); #1;
    do_req(5, 3, lat, wt, e);
    total++; if (wt != model(5, 3, 8, SAT)) begin bad++; $display("FAIL b2b_wt got=%0d want=%0d", wt, model(5, 3, 8, SAT)); end
    total++; if (lat != 9) begin bad++; $display("FAIL b2b_lat got=%0d want=9", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    int lat;
    bus4.count = 3'd7; bus4.tellers = 2'd1; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (bus4.done) begin lat = i; break; end
      @(posedge clk); #1;
    end
    total++; if (lat != 9) begin bad++; $display("FAIL sat_lat got=%0d want=9", lat); end
    total++; if (int'(bus4.wait_time) != model(7, 1, 4, SAT)) begin bad++; $display("FAIL sat_wt got=%0d want=%0d", bus4.wait_time, model(7, 1, 4, SAT)); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat, wt, c, t;
    logic e;
    for (int n = 0; n < 40; n++) begin
      c = int'($urandom_range(0, 7));
      t = int'($urandom_range(0, 3));
      do_req(c, t, lat, wt, e);
      total++; if (wt != model(c, t, 8, SAT)) begin bad++; $display("FAIL rand_wt t=%0d c=%0d got=%0d want=%0d", t, c, wt, model(c, t, 8, SAT)); end
      total++; if (e !== (t == 0)) begin bad++; $display("FAIL rand_err t=%0d c=%0d got=%b want=%b", t, c, e, (t == 0)); end
      total++; if (lat != model_lat(c, t)) begin bad++; $display("FAIL rand_lat t=%0d c=%0d got=%0d want=%0d", t, c, lat, model_lat(c, t)); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_sweep();
    test_reset_mid_div();
    test_illegal();
    test_start_while_busy();
    test_hold_back_to_back();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wait_time_calc.md
Name: wait_time_calc

Overview:
Sequential, parametrised successor to the fixed teller/queue wait-time lookup. It computes the estimated customer wait for any teller count and queue length with one closed-form rule. The rule is wait = floor(SERVICE_TIME*(count+tellers-1)/tellers), forced to 0 when count==0. It sits between the queue counter and the display driver, uses a start/done handshake, and has a fixed latency.

Parameters:
COUNT_W, 3, width of queue-length input
TELLER_W, 2, width of teller-count input
MAX_TELLERS, 3, largest legal teller count
SERVICE_TIME, 3, service time per customer, in display units
OUT_W, 8, width of wait_time output

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request; sampled only in IDLE
count  in  COUNT_W  queue length; captured on accepted start
tellers  in  TELLER_W  active tellers; captured on accepted start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse; result valid
err  out  1  illegal teller count; valid with done, held until next start
wait_time  out  OUT_W  result; held until next accepted start

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, err=0, wait_time=0. Reset mid-operation aborts the computation and discards it.
- ST_W = clog2(SERVICE_TIME+1). Dividend width DIVD_W = COUNT_W+TELLER_W+ST_W. Arithmetic is unsigned with no overflow inside DIVD_W.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: start=1 captures count and tellers, clears err.
    - tellers==0 or tellers>MAX_TELLERS: go to DONE with err=1 and wait_time=0.
    - count==0: go to DONE with wait_time=0.
    - Otherwise: go to MUL.
  - MUL: 1 cycle; dividend = SERVICE_TIME*(count+tellers-1); divisor = tellers.
  - DIV: restoring division, one quotient bit per cycle, exactly DIVD_W cycles, MSB first; remainder discarded.
  - DONE: 1 cycle; done=1; wait_time = quotient resized to OUT_W, truncated unless the optional feature is enabled; then IDLE.
- Latency: start is sampled at edge E0. Normal path: done is high in cycle DIVD_W+2 after E0 (9 cycles at defaults). Zero-count and err paths: done is high in cycle 1.
- start while busy is ignored, not queued. start in the DONE cycle is ignored; start is accepted again from the following IDLE cycle.
- count and tellers may change freely after capture without effect.
- Inputs are captured once per request, so results are stable and reproducible.

Optional Feature:
- Macro WAIT_SAT_EN.
  - Defined: a quotient exceeding 2^OUT_W-1 is clamped to all-ones.
  - Undefined: the quotient is truncated to its OUT_W LSBs.
- The err behaviour is the same in both builds.

Decomposition:
- Package wait_calc_pkg holds:
  - the FSM state enum (IDLE, MUL, DIV, DONE);
  - a clog2 function;
  - the ST_W and DIVD_W derivation functions.
- One sub-module is natural: seq_divider (DIVD_W-bit unsigned restoring divider with load/busy/done). wait_time_calc instantiates it in the DIV phase.

Test Plan:
- Reset mid-DIV: pulse rst_n low while busy -> busy, done, err and wait_time are all 0 immediately; a new start after release computes normally.
- Full default sweep: tellers 1..3 x count 0..7, compared against the rule.
  - Tellers=1 -> 0,3,6,9,12,15,18,21.
  - Tellers=2 -> 0,3,4,6,7,9,10,12.
  - Tellers=3 -> 0,3,4,5,6,7,8,9.
  - Each done arrives exactly 9 cycles after start (1 cycle for count=0).
- Illegal tellers: tellers=0, count=5 -> done after 1 cycle, err=1, wait_time=0. A following legal start (tellers=2, count=5) -> err=0, wait_time=9.
- Start while busy: tellers=3, count=7, then start again at cycle 4 with tellers=1, count=7 -> exactly one done, wait_time=9; second start ignored.
- Saturation, OUT_W=4, tellers=1, count=7 (quotient 21):
  - WAIT_SAT_EN defined -> wait_time=15.
  - WAIT_SAT_EN undefined -> wait_time=5.
- Hold and back-to-back: after done, wait_time is stable for 20 idle cycles while inputs toggle. A start in the first IDLE cycle after DONE is accepted.
